fm25l16_spi_responder: RTL and testbench
========================================

Name: fm25l16_spi_responder

Overview:
- SPI mode-0 slave that emulates the FM25L16 FRAM command set: WREN, WRDI, RDSR, READ, WRITE.
- It is the far end of the SPI memory master. It serves as the on-chip or bench model the master talks to over spi_sck / spi_cs_n / spi_mosi / spi_miso.
- Fully synchronous to clk: SPI pins are synchronized and edge-detected internally, and storage is an internal byte array.

Parameters:
- ADDR_W, 6, number of used address bits; the array holds 2**ADDR_W bytes. The 16-bit protocol address is truncated to its low ADDR_W bits.
- SYNC_STAGES, 2, synchronizer flops on spi_sck, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock; must be at least 8x the spi_sck frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sck  in  1  SPI clock from the master; idles low (mode 0).
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data, MSB first.
- spi_miso_oe  out  1  high while the slave drives spi_miso.
- wel  out  1  write-enable latch (mirrors status bit 1).
- wr_strobe  out  1  one-clk pulse per byte committed to the array.
- bd_addr  in  ADDR_W  backdoor read address (test/debug).
- bd_rdata  out  8  combinational array[bd_addr].

Behaviour:
- Reset: state=IDLE, wel=0, spi_miso=0, spi_miso_oe=0, wr_strobe=0, bit/byte counters=0, address register=0, all array bytes=0x00.
- Edge detection: sck_rise and sck_fall are derived after SYNC_STAGES plus one edge flop. This gives pin-to-action latency of SYNC_STAGES+1 clk cycles.
- cs_n=1 (synchronized) at any time forces IDLE at the next clk, regardless of state:
  - bit counter is cleared;
  - spi_miso_oe=0 and spi_miso=0;
  - any partial byte is discarded.
- Leaving a WRITE command this way (cs_n rising) clears wel.
- Receive: spi_mosi is sampled on sck_rise into an 8-bit shift register. A byte completes on the 8th rise.
- Transmit: spi_miso changes only on sck_fall, or on the clk where a new byte is loaded for output.
- States:
  - IDLE: waits for cs_n=0, then goes to OPCODE.
  - OPCODE: on byte completion:
    - 0x06 (WREN): wel<=1, go to IGNORE.
    - 0x04 (WRDI): wel<=0, go to IGNORE.
    - 0x05 (RDSR): go to STATUS.
    - 0x03 (READ): go to ADDR_HI.
    - 0x02 (WRITE): go to ADDR_HI.
    - any other opcode: go to IGNORE.
  - ADDR_HI: receives the address high byte, then goes to ADDR_LO.
  - ADDR_LO: on completion, addr <= {hi,lo}[ADDR_W-1:0].
    - READ: tx shift register <= array[addr], go to RD_DATA.
    - WRITE: go to WR_DATA.
  - RD_DATA:
    - spi_miso_oe=1.
    - MSB is presented on the first sck_fall after the 24th rise; the remaining bits follow on subsequent falls.
    - After the 8th bit is shifted out: addr <= addr+1 (wraps 2**ADDR_W-1 -> 0), then the next byte loads.
  - WR_DATA: on each completed byte:
    - if wel=1: array[addr] <= byte, wr_strobe=1 for one clk, then addr <= addr+1 (wrap).
    - if wel=0: byte is dropped, no strobe, addr still increments.
  - STATUS: repeatedly shifts out {6'b0, wel, 1'b0} with spi_miso_oe=1, using the same timing as RD_DATA.
  - IGNORE: stays until cs_n=1; no output and no side effects.
- Simultaneous events:
  - cs_n deassert in the same clk as a byte completion: the deassert wins and the byte is not committed.
  - Backdoor read in the same clk as a write: bd_rdata shows the pre-write value.
- Opcode is recognized only as the first byte after cs_n falls. The slave never initiates traffic.

Decomposition:
- Package fm25l16_pkg:
  - opcode constants OP_WREN=0x06, OP_WRDI=0x04, OP_RDSR=0x05, OP_READ=0x03, OP_WRITE=0x02;
  - status bit index SR_WEL=1;
  - state encoding IDLE, OPCODE, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, STATUS, IGNORE.
- One sub-module, spi_pin_sync: SYNC_STAGES synchronizer plus edge detector, producing sck_rise, sck_fall, cs_n_s and mosi_s.

Test Plan:
- WREN frame, then WRITE 0x0005 with data 0xA5, 0x3C -> wr_strobe pulses twice; bd_addr 5 reads 0xA5 and bd_addr 6 reads 0x3C; wel=0 after cs_n rises.
- WRITE 0x0010 with data 0x77 without a prior WREN -> no wr_strobe; array[0x10] stays 0x00.
- After the writes above, READ 0x0005 clocking 16 data bits -> spi_miso returns 0xA5 then 0x3C; spi_miso_oe is high only during the data phase.
- WREN, then RDSR -> 0x02 read back; WRDI, then RDSR -> 0x00.
- WREN, then WRITE 0x003F with 0x11, 0x22 -> array[63]=0x11 and array[0]=0x22 (wrap).
- WREN, then WRITE 0x0008 with 5 data bits followed by cs_n high; a later rst_n pulse mid-READ -> array[8] unchanged; after reset, outputs are at reset values and all bytes are 0x00.

Source files
------------

// File: rtl/fm25l16_pkg.sv
// Shared definitions for the FM25L16-style SPI responder: opcodes, status layout, FSM states.
package fm25l16_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int SR_WEL = 1;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDR_HI,
    ADDR_LO,
    RD_DATA,
    WR_DATA,
    STATUS,
    IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] sr;
    sr         = 8'h00;
    sr[SR_WEL] = wel;
    return sr;
  endfunction

endpackage

// File: rtl/fm25l16_spi_responder_sync.sv
// SPI pin synchronizer plus sck edge detector; every output lags its pin by SYNC_STAGES clocks.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_sck_sync[0]  <= spi_sck;
      r_cs_sync[0]   <= spi_cs_n;
      r_mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sck_sync[i]  <= r_sck_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_sck_d <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
  assign sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
  assign cs_n_s   = r_cs_sync[SYNC_STAGES-1];
  assign mosi_s   = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/fm25l16_spi_responder.sv
// SPI mode-0 slave emulating the FM25L16 FRAM command set over a small internal byte array.
module fm25l16_spi_responder
  import fm25l16_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wel,
  output logic              wr_strobe,
  input  logic [ADDR_W-1:0] bd_addr,
  output logic [7:0]        bd_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              w_sck_rise, w_sck_fall, w_cs_n_s, w_mosi_s;
  logic [7:0]        r_mem [DEPTH];
  state_e            r_state;
  logic [7:0]        r_rx_sh, r_tx_sh, r_addr_hi;
  logic [2:0]        r_bit_cnt, r_tx_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wel, r_miso, r_oe, r_wr_strobe, r_is_write;

  logic [7:0]        w_rx_byte;
  logic              w_byte_done, w_mem_we;
  logic [15:0]       w_full_addr;
  logic [ADDR_W-1:0] w_new_addr, w_addr_inc;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .sck_rise (w_sck_rise),
    .sck_fall (w_sck_fall),
    .cs_n_s   (w_cs_n_s),
    .mosi_s   (w_mosi_s)
  );

  assign w_rx_byte   = {r_rx_sh[6:0], w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7) && (r_state != IDLE);
  assign w_full_addr = {r_addr_hi, w_rx_byte};
  assign w_new_addr  = w_full_addr[ADDR_W-1:0];
  assign w_addr_inc  = r_addr + 1'b1;
  // A deasserting chip select outranks a byte completing in the same clk.
  assign w_mem_we    = !w_cs_n_s && (r_state == WR_DATA) && w_byte_done && r_wel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_mem_we) begin
      r_mem[r_addr] <= w_rx_byte;
    end
  end

  assign bd_rdata = r_mem[bd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_sh     <= 8'h00;
      r_tx_sh     <= 8'h00;
      r_addr_hi   <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_tx_cnt    <= 3'd0;
      r_addr      <= '0;
      r_wel       <= 1'b0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_is_write  <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_cs_n_s) begin
        if (r_is_write) r_wel <= 1'b0;
        r_state    <= IDLE;
        r_bit_cnt  <= 3'd0;
        r_tx_cnt   <= 3'd0;
        r_miso     <= 1'b0;
        r_oe       <= 1'b0;
        r_is_write <= 1'b0;
      end else begin
        if (w_sck_rise && r_state != IDLE) begin
          r_rx_sh   <= w_rx_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        case (r_state)
          IDLE: r_state <= OPCODE;
          OPCODE: if (w_byte_done) begin
            r_is_write <= (w_rx_byte == OP_WRITE);
            case (w_rx_byte)
              OP_WREN: begin r_wel <= 1'b1; r_state <= IGNORE; end
              OP_WRDI: begin r_wel <= 1'b0; r_state <= IGNORE; end
              OP_RDSR: begin
                r_tx_sh  <= status_byte(r_wel);
                r_tx_cnt <= 3'd0;
                r_oe     <= 1'b1;
                r_state  <= STATUS;
              end
              OP_READ, OP_WRITE: r_state <= ADDR_HI;
              default: r_state <= IGNORE;
            endcase
          end
          ADDR_HI: if (w_byte_done) begin
            r_addr_hi <= w_rx_byte;
            r_state   <= ADDR_LO;
          end
          ADDR_LO: if (w_byte_done) begin
            r_addr <= w_new_addr;
            if (r_is_write) begin
              r_state <= WR_DATA;
            end else begin
              r_tx_sh  <= r_mem[w_new_addr];
              r_tx_cnt <= 3'd0;
              r_oe     <= 1'b1;
              r_state  <= RD_DATA;
            end
          end
          RD_DATA, STATUS: if (w_sck_fall) begin
            r_miso   <= r_tx_sh[7];
            r_tx_cnt <= r_tx_cnt + 3'd1;
            if (r_tx_cnt == 3'd7) begin
              if (r_state == RD_DATA) begin
                r_addr  <= w_addr_inc;
                r_tx_sh <= r_mem[w_addr_inc];
              end else begin
                r_tx_sh <= status_byte(r_wel);
              end
            end else begin
              r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
          end
          WR_DATA: if (w_byte_done) begin
            r_addr      <= w_addr_inc;
            r_wr_strobe <= r_wel;
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign wel         = r_wel;
  assign wr_strobe   = r_wr_strobe;

endmodule

// File: tb/tb_fm25l16_spi_responder.sv
// Directed bench: drives SPI mode-0 frames and checks array, status and readback against hand values.
module tb_fm25l16_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, wel, wr_strobe;
  logic [5:0] bd_addr = 6'd0;
  logic [7:0] bd_rdata;

  int n_pass = 0;
  int n_total = 0;
  int strobe_cnt = 0;

  logic [7:0] rx;
  logic       oe_any, oe_all;

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  fm25l16_spi_responder #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wel         (wel),
    .wr_strobe   (wr_strobe),
    .bd_addr     (bd_addr),
    .bd_rdata    (bd_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic bd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    bd_addr = a;
    #1;
    chk(tag, {24'd0, bd_rdata}, {24'd0, exp});
  endtask

  // Master samples miso just before raising sck; slave updates it only after falls.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rxo, output logic any, output logic all);
    rxo = 8'h00; any = 1'b0; all = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = tx[7-b];
      repeat (8) @(negedge clk);
      rxo = {rxo[6:0], spi_miso};
      any = any | spi_miso_oe;
      all = all & spi_miso_oe;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic cmd_only(input logic [7:0] op);
    frame_begin();
    xfer(op, 8, rx, oe_any, oe_all);
    frame_end();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_wel", {31'd0, wel}, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    bd_chk("rst_mem0", 6'd0, 8'h00);

    // WREN then WRITE 0x0005 A5 3C
    cmd_only(8'h06);
    chk("wren_wel", {31'd0, wel}, 32'd1);
    frame_begin();
    xfer(8'h02, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h05, 8, rx, oe_any, oe_all);
    xfer(8'hA5, 8, rx, oe_any, oe_all);
    xfer(8'h3C, 8, rx, oe_any, oe_all);
    frame_end();
    chk("wr_strobes", strobe_cnt, 32'd2);
    bd_chk("mem5", 6'd5, 8'hA5);
    bd_chk("mem6", 6'd6, 8'h3C);
    chk("wel_after_wr", {31'd0, wel}, 32'd0);

    // WRITE 0x0010 77 without WREN
    frame_begin();
    xfer(8'h02, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h10, 8, rx, oe_any, oe_all);
    xfer(8'h77, 8, rx, oe_any, oe_all);
    frame_end();
    chk("nowel_strobes", strobe_cnt, 32'd2);
    bd_chk("mem10", 6'h10, 8'h00);

    // READ 0x0005, two data bytes
    frame_begin();
    xfer(8'h03, 8, rx, oe_any, oe_all);
    chk("rd_op_oe", {31'd0, oe_any}, 32'd0);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rd_hi_oe", {31'd0, oe_any}, 32'd0);
    xfer(8'h05, 8, rx, oe_any, oe_all);
    chk("rd_lo_oe", {31'd0, oe_any}, 32'd0);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rd_byte0", {24'd0, rx}, 32'hA5);
    chk("rd_d0_oe", {31'd0, oe_all}, 32'd1);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rd_byte1", {24'd0, rx}, 32'h3C);
    chk("rd_d1_oe", {31'd0, oe_all}, 32'd1);
    frame_end();
    chk("rd_oe_end", {31'd0, spi_miso_oe}, 32'd0);
    chk("rd_miso_end", {31'd0, spi_miso}, 32'd0);

    // READ 0x1FC5 truncates to 0x05
    frame_begin();
    xfer(8'h03, 8, rx, oe_any, oe_all);
    xfer(8'h1F, 8, rx, oe_any, oe_all);
    xfer(8'hC5, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    frame_end();
    chk("rd_trunc", {24'd0, rx}, 32'hA5);

    // RDSR after WREN and after WRDI
    cmd_only(8'h06);
    frame_begin();
    xfer(8'h05, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rdsr_wel1", {24'd0, rx}, 32'h02);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rdsr_rep", {24'd0, rx}, 32'h02);
    frame_end();
    cmd_only(8'h04);
    chk("wrdi_wel", {31'd0, wel}, 32'd0);
    frame_begin();
    xfer(8'h05, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rdsr_wel0", {24'd0, rx}, 32'h00);
    frame_end();

    // WRITE 0x003F 11 22 wraps to address 0
    cmd_only(8'h06);
    frame_begin();
    xfer(8'h02, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h3F, 8, rx, oe_any, oe_all);
    xfer(8'h11, 8, rx, oe_any, oe_all);
    xfer(8'h22, 8, rx, oe_any, oe_all);
    frame_end();
    chk("wrap_strobes", strobe_cnt, 32'd4);
    bd_chk("mem63", 6'd63, 8'h11);
    bd_chk("mem0_wrap", 6'd0, 8'h22);

    // READ across the wrap
    frame_begin();
    xfer(8'h03, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h3F, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rdwrap_b0", {24'd0, rx}, 32'h11);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    chk("rdwrap_b1", {24'd0, rx}, 32'h22);
    frame_end();

    // Partial byte then cs_n high: nothing committed
    cmd_only(8'h06);
    frame_begin();
    xfer(8'h02, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h08, 8, rx, oe_any, oe_all);
    xfer(8'hFF, 5, rx, oe_any, oe_all);
    frame_end();
    chk("part_strobes", strobe_cnt, 32'd4);
    bd_chk("mem8", 6'd8, 8'h00);
    chk("part_wel", {31'd0, wel}, 32'd0);

    // Reset in the middle of a READ
    frame_begin();
    xfer(8'h03, 8, rx, oe_any, oe_all);
    xfer(8'h00, 8, rx, oe_any, oe_all);
    xfer(8'h05, 8, rx, oe_any, oe_all);
    xfer(8'h00, 4, rx, oe_any, oe_all);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_wel", {31'd0, wel}, 32'd0);
    chk("mrst_miso", {31'd0, spi_miso}, 32'd0);
    chk("mrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("mrst_strobe", {31'd0, wr_strobe}, 32'd0);
    for (int a = 0; a < 64; a++) bd_chk($sformatf("mrst_mem%0d", a), a[5:0], 8'h00);
    frame_end();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
